// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the shift-add multiplier scheduler.
// Build option: define MUL_SCHED_UNSIGNED_EN for unsigned operands (default is signed).
package mul_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } sched_state_e;

`ifdef MUL_SCHED_UNSIGNED_EN
    localparam bit MUL_SIGNED = 1'b0;
`else
    localparam bit MUL_SIGNED = 1'b1;
`endif

endpackage

// File: rtl/mul_shift_core.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_WIDTH cycles per product.
// done pulses during the final iteration; res carries the finished product in that cycle.
module mul_shift_core
    import mul_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   x,
    input  logic [DATA_WIDTH-1:0]   y,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] res
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                    run;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] x_sh;
    logic [DATA_WIDTH-1:0]   y_sh;
    logic [2*DATA_WIDTH-1:0] x_ext;
    logic [2*DATA_WIDTH-1:0] term;
    logic [2*DATA_WIDTH-1:0] acc_nxt;
    logic                    last;

    always_comb begin
        x_ext = MUL_SIGNED ? {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x} : {{DATA_WIDTH{1'b0}}, x};
        last  = run && (cnt == CNT_W'(DATA_WIDTH - 1));
        term  = y_sh[0] ? x_sh : '0;
        // The multiplier's sign bit carries negative weight in two's complement.
        acc_nxt = (MUL_SIGNED && last) ? (acc - term) : (acc + term);
    end

    assign done = last;
    assign res  = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run  <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            x_sh <= '0;
            y_sh <= '0;
        end else if (start) begin
            run  <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            x_sh <= x_ext;
            y_sh <= y;
        end else if (run) begin
            acc  <= acc_nxt;
            x_sh <= x_sh << 1;
            y_sh <= y_sh >> 1;
            if (last) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_shift_sched.sv
// Round-robin scheduler sharing one shift-add multiplier among REQ_NUM requesters.
// Signedness follows MUL_SCHED_UNSIGNED_EN (see mul_sched_pkg).
module mul_shift_sched
    import mul_sched_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int REQ_NUM    = 4,
    localparam int ID_WIDTH   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [REQ_NUM-1:0]              i_req_valid,
    output logic [REQ_NUM-1:0]              o_req_ready,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   i_req_num_x,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]   i_req_num_y,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [ID_WIDTH-1:0]             o_rsp_id,
    output logic [2*DATA_WIDTH-1:0]         o_rsp_res,
    output logic                            o_busy
);

    sched_state_e            state;
    logic [ID_WIDTH-1:0]     ptr;
    logic [ID_WIDTH-1:0]     cur_id;
    logic                    gnt_found;
    logic [ID_WIDTH-1:0]     gnt_id;
    logic [ID_WIDTH-1:0]     next_ptr;
    logic [REQ_NUM-1:0]      gnt_oh;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   sel_x;
    logic [DATA_WIDTH-1:0]   sel_y;
    logic                    core_done;
    logic [2*DATA_WIDTH-1:0] core_res;

    // First valid requester scanning upward from ptr, wrapping at REQ_NUM.
    always_comb begin
        logic [ID_WIDTH:0]   sum;
        logic [ID_WIDTH-1:0] idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            sum = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
            if (sum >= (ID_WIDTH + 1)'(REQ_NUM)) begin
                sum = sum - (ID_WIDTH + 1)'(REQ_NUM);
            end
            idx = sum[ID_WIDTH-1:0];
            if (!gnt_found && i_req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        gnt_oh         = '0;
        gnt_oh[gnt_id] = 1'b1;
        next_ptr       = (gnt_id == ID_WIDTH'(REQ_NUM - 1)) ? '0 : gnt_id + 1'b1;
    end

    assign accept      = (state == S_IDLE) && gnt_found;
    assign o_req_ready = (accept && i_rst_n) ? gnt_oh : '0;
    assign sel_x       = i_req_num_x[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign sel_y       = i_req_num_y[gnt_id*DATA_WIDTH +: DATA_WIDTH];

    mul_shift_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (accept),
        .x     (sel_x),
        .y     (sel_y),
        .done  (core_done),
        .res   (core_res)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cur_id      <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_res   <= '0;
            o_busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_id <= gnt_id;
                        ptr    <= next_ptr;
                        o_busy <= 1'b1;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (core_done) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_id    <= cur_id;
                        o_rsp_res   <= core_res;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Returning to idle here keeps new grants out of the response handshake cycle.
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
